// File: rtl/spi_adc_scan_master.sv
// SPI Mode 0 master for MCP300x/MCP320x SAR ADCs with single-shot and round-robin scan modes.
// Define SPI_ADC_LSBCHK_EN to extend each frame and cross-check the device's LSB-first echo.
module spi_adc_scan_master #(
   parameter int unsigned DATA_W  = 10,
   parameter int unsigned NUM_CH  = 8,
   parameter int unsigned CLK_DIV = 4,
   parameter int unsigned CS_IDLE = 14
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              scan_en,
   input  logic              single,
   input  logic [2:0]        channel,
   input  logic [NUM_CH-1:0] ch_mask,
   input  logic              MISO,
   output logic              MOSI,
   output logic              SCK,
   output logic              CS,
   output logic              busy,
   output logic [DATA_W-1:0] adc_data,
   output logic [2:0]        adc_ch,
   output logic              data_valid,
   output logic              data_err
);

`ifdef SPI_ADC_LSBCHK_EN
   localparam int unsigned N = 6 + 2 * DATA_W;
`else
   localparam int unsigned N = 7 + DATA_W;
`endif
   localparam int unsigned DivW = $clog2(CLK_DIV);
   localparam int unsigned GapW = $clog2(CS_IDLE + 1);
   localparam logic [DivW-1:0] DivLast   = DivW'(CLK_DIV - 1);
   localparam logic [GapW-1:0] GapLast   = GapW'(CS_IDLE - 1);
   localparam logic [5:0]      BitLast   = 6'(N);
   localparam logic [5:0]      DataFirst = 6'd8;
   localparam logic [5:0]      DataLast  = 6'(7 + DATA_W);
   localparam logic            HasD2     = (NUM_CH == 8);

   typedef enum logic [1:0] {StIdle, StSetup, StShift, StGap} state_e;

   state_e            state;
   logic [DivW-1:0]   div_cnt;
   logic [GapW-1:0]   gap_cnt;
   logic [5:0]        bit_cnt;
   logic [2:0]        ch_q;
   logic              single_q;
   logic              scan_q;
   logic [DATA_W-1:0] shift_q;
   logic              next_mosi;
   logic              sck_tick;
   logic              sck_rise;
   logic              last_fall;
   logic              scan_go;

   // First enabled channel at or above 'from', wrapping to the lowest enabled one.
   function automatic logic [2:0] scan_pick(input logic [NUM_CH-1:0] mask, input int from);
      logic [NUM_CH-1:0] m;
      logic [2:0]        lo;
      logic [2:0]        hi;
      logic              got_lo;
      logic              got_hi;
      lo     = '0;
      hi     = '0;
      got_lo = 1'b0;
      got_hi = 1'b0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
         m = mask >> i;
         if (m[0] && !got_lo) begin
            lo     = 3'(i);
            got_lo = 1'b1;
         end
         if (m[0] && !got_hi && i >= from) begin
            hi     = 3'(i);
            got_hi = 1'b1;
         end
      end
      return got_hi ? hi : lo;
   endfunction

   assign sck_tick  = (state == StShift) && (div_cnt == DivLast);
   assign sck_rise  = sck_tick && !SCK;
   assign last_fall = sck_tick && SCK && (bit_cnt == BitLast);
   assign scan_go   = scan_q && scan_en && (ch_mask != '0);

   // Command bit for the SCK cycle following the current one.
   always_comb begin
      case (bit_cnt)
         6'd1:    next_mosi = single_q;
         6'd2:    next_mosi = ch_q[2];
         6'd3:    next_mosi = ch_q[1];
         6'd4:    next_mosi = ch_q[0];
         default: next_mosi = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= StIdle;
         div_cnt    <= '0;
         gap_cnt    <= '0;
         bit_cnt    <= '0;
         ch_q       <= '0;
         single_q   <= 1'b0;
         scan_q     <= 1'b0;
         shift_q    <= '0;
         CS         <= 1'b1;
         SCK        <= 1'b0;
         MOSI       <= 1'b0;
         busy       <= 1'b0;
         adc_data   <= '0;
         adc_ch     <= '0;
         data_valid <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         unique case (state)
            StIdle: begin
               if (start && (!scan_en || ch_mask != '0)) begin
                  state    <= StSetup;
                  scan_q   <= scan_en;
                  single_q <= single;
                  ch_q     <= scan_en ? scan_pick(ch_mask, 0) : {channel[2] & HasD2, channel[1:0]};
               end
            end
            StSetup: begin
               // CS still high means this is the cycle right after accept.
               if (CS) begin
                  CS      <= 1'b0;
                  busy    <= 1'b1;
                  MOSI    <= 1'b1;
                  bit_cnt <= 6'd1;
                  div_cnt <= '0;
               end else if (div_cnt == DivLast) begin
                  SCK     <= 1'b1;
                  div_cnt <= '0;
                  state   <= StShift;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            StShift: begin
               if (!sck_tick) begin
                  div_cnt <= div_cnt + 1'b1;
               end else if (sck_rise) begin
                  div_cnt <= '0;
                  SCK     <= 1'b1;
                  if (bit_cnt >= DataFirst && bit_cnt <= DataLast) begin
                     shift_q <= {shift_q[DATA_W-2:0], MISO};
                  end
               end else if (last_fall) begin
                  div_cnt    <= '0;
                  SCK        <= 1'b0;
                  CS         <= 1'b1;
                  MOSI       <= 1'b0;
                  adc_data   <= shift_q;
                  adc_ch     <= ch_q;
                  data_valid <= 1'b1;
                  gap_cnt    <= '0;
                  state      <= StGap;
               end else begin
                  div_cnt <= '0;
                  SCK     <= 1'b0;
                  MOSI    <= next_mosi;
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            StGap: begin
               if (gap_cnt != GapLast) begin
                  gap_cnt <= gap_cnt + 1'b1;
               end else if (scan_go) begin
                  // Next scan frame starts with CS falling on the gap's last edge.
                  CS       <= 1'b0;
                  MOSI     <= 1'b1;
                  bit_cnt  <= 6'd1;
                  div_cnt  <= '0;
                  single_q <= single;
                  ch_q     <= scan_pick(ch_mask, int'(ch_q) + 1);
                  state    <= StSetup;
               end else begin
                  busy  <= 1'b0;
                  state <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

`ifdef SPI_ADC_LSBCHK_EN
   localparam logic [5:0] EchoFirst = 6'(8 + DATA_W);

   // echo_q[i] ends up holding B(i+1) of the LSB-first echo.
   logic [DATA_W-2:0] echo_q;
   logic              err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         echo_q <= '0;
         err_q  <= 1'b0;
      end else begin
         if (sck_rise && bit_cnt >= EchoFirst && bit_cnt <= BitLast) begin
            echo_q <= {MISO, echo_q[DATA_W-2:1]};
         end
         if (last_fall) begin
            err_q <= (echo_q != shift_q[DATA_W-1:1]);
         end
      end
   end

   assign data_err = err_q;
`else
   assign data_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_adc_scan_master.sv
// Self-checking bench for spi_adc_scan_master: behavioural MCP3x0x slave plus a result scoreboard.
`timescale 1ns/1ps
module tb_spi_adc_scan_master;

`ifdef SPI_ADC_LSBCHK_EN
   localparam int DW = 12;
   localparam int CD = 2;
   localparam int N  = 6 + 2 * DW;
`else
   localparam int DW = 10;
   localparam int CD = 4;
   localparam int N  = 7 + DW;
`endif
   localparam int GAP = 14;
   localparam int TDV = 1 + 2 * N * CD;
   localparam int P   = 2 * N * CD + GAP;

   typedef struct packed {
      logic          err;
      logic [2:0]    ch;
      logic [DW-1:0] data;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          scan_en;
   logic          single;
   logic [2:0]    channel;
   logic [7:0]    ch_mask;
   logic          MISO = 1'b0;
   logic          MOSI;
   logic          SCK;
   logic          CS;
   logic          busy;
   logic [DW-1:0] adc_data;
   logic [2:0]    adc_ch;
   logic          data_valid;
   logic          data_err;

   int   n_tests;
   int   n_fail;
   exp_t exp_q[$];

   spi_adc_scan_master #(
      .DATA_W (DW),
      .NUM_CH (8),
      .CLK_DIV(CD),
      .CS_IDLE(GAP)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .scan_en   (scan_en),
      .single    (single),
      .channel   (channel),
      .ch_mask   (ch_mask),
      .MISO      (MISO),
      .MOSI      (MOSI),
      .SCK       (SCK),
      .CS        (CS),
      .busy      (busy),
      .adc_data  (adc_data),
      .adc_ch    (adc_ch),
      .data_valid(data_valid),
      .data_err  (data_err)
   );

   always #5 clk = ~clk;

   // ADC slave model: counts SCK rises, captures the command, presents the next bit after each rise.
   int            sl_k = 0;
   int            sl_mode = 0;
   int            flip_k = 0;
   int            frames = 0;
   logic [DW-1:0] sl_fixed = '0;
   logic [4:0]    sl_cmd = '0;
   logic          sck_prev = 1'b0;
   logic          cs_prev = 1'b1;

   function automatic logic miso_bit(input int k, input logic [DW-1:0] w, input int fk);
      logic b;
      b = 1'b0;
      if (k >= 8 && k <= 7 + DW) b = w[DW - 1 - (k - 8)];
      else if (k >= 8 + DW && k <= 6 + 2 * DW) b = w[k - 7 - DW];
      if (k == fk) b = ~b;
      return b;
   endfunction

   always @(posedge clk) begin
      #1;
      if (CS) begin
         sl_k = 0;
         MISO = 1'b0;
      end else begin
         if (cs_prev) frames++;
         if (SCK && !sck_prev) begin
            sl_k++;
            if (sl_k <= 5) sl_cmd = {sl_cmd[3:0], MOSI};
         end
         MISO = miso_bit(sl_k + 1, (sl_mode == 1) ? DW'(256 + int'(sl_cmd[2:0])) : sl_fixed,
                         flip_k);
      end
      cs_prev  = CS;
      sck_prev = SCK;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if ({CS, SCK, MOSI, busy, data_valid, data_err, adc_ch, adc_data} !== {1'b1, 5'b0, 3'b0, DW'(0)}) begin
         n_fail++;
         $display("FAIL reset_held: got CS=%b SCK=%b MOSI=%b busy=%b dv=%b err=%b ch=%0d data=%0h, want 1 0 0 0 0 0 0 0",
                  CS, SCK, MOSI, busy, data_valid, data_err, adc_ch, adc_data);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if ({CS, SCK, MOSI, busy, data_valid} !== 5'b10000) begin
         n_fail++;
         $display("FAIL reset_released_idle: got CS/SCK/MOSI/busy/dv=%b, want 10000",
                  {CS, SCK, MOSI, busy, data_valid});
      end
   endtask

   task automatic test_single_conv(input string name, input logic sgl, input logic [2:0] ch,
                                   input logic [DW-1:0] word, input int fk, input logic exp_err);
      int   cs_fall, dv_at, dv_cnt, cs_low, busy_fall;
      logic busy_at1;
      exp_t e;
      exp_q.push_back({exp_err, ch, word});
      sl_mode  = 0;
      sl_fixed = word;
      flip_k   = fk;
      @(negedge clk);
      single  = sgl;
      channel = ch;
      scan_en = 1'b0;
      start   = 1'b1;
      @(posedge clk);
      #1;
      start     = 1'b0;
      cs_fall   = -1;
      dv_at     = -1;
      dv_cnt    = 0;
      cs_low    = 0;
      busy_fall = -1;
      busy_at1  = 1'b0;
      for (int j = 1; j <= TDV + GAP + 10; j++) begin
         @(posedge clk);
         #1;
         if (j == 1) busy_at1 = busy;
         if (!CS) begin
            cs_low++;
            if (cs_fall < 0) cs_fall = j;
         end
         if (busy_fall < 0 && j > 1 && !busy) busy_fall = j;
         if (data_valid) begin
            dv_cnt++;
            dv_at = j;
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL %s_extra_valid: got data_valid with ch=%0d, want none", name, adc_ch);
            end else begin
               e = exp_q.pop_front();
               if ({data_err, adc_ch, adc_data} !== e) begin
                  n_fail++;
                  $display("FAIL %s_result: got err=%0b ch=%0d data=%0h, want err=%0b ch=%0d data=%0h",
                           name, data_err, adc_ch, adc_data, e.err, e.ch, e.data);
               end
            end
         end
      end
      n_tests++;
      if (cs_fall != 1 || busy_at1 !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_cs_fall: got CS fall at T+%0d busy=%b, want T+1 busy=1", name, cs_fall, busy_at1);
      end
      n_tests++;
      if (dv_at != TDV || dv_cnt != 1) begin
         n_fail++;
         $display("FAIL %s_valid_timing: got %0d pulses last at T+%0d, want 1 at T+%0d", name, dv_cnt, dv_at, TDV);
      end
      n_tests++;
      if (cs_low != 2 * N * CD) begin
         n_fail++;
         $display("FAIL %s_cs_low: got %0d cycles, want %0d", name, cs_low, 2 * N * CD);
      end
      n_tests++;
      if (busy_fall != TDV + GAP) begin
         n_fail++;
         $display("FAIL %s_busy_fall: got T+%0d, want T+%0d", name, busy_fall, TDV + GAP);
      end
      n_tests++;
      if (sl_cmd !== {1'b1, sgl, ch}) begin
         n_fail++;
         $display("FAIL %s_mosi_cmd: got %b, want %b", name, sl_cmd, {1'b1, sgl, ch});
      end
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s_missing_result: got %0d unconsumed, want 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_scan();
      int       dv_seen, busy_fall, drop_at, busy_low_early, frames_end;
      int       dv_at[5];
      int       seq[5];
      exp_t     e;
      seq = '{2, 5, 7, 2, 5};
      for (int i = 0; i < 5; i++) begin
         dv_at[i] = 0;
         exp_q.push_back({1'b0, 3'(seq[i]), DW'(256 + seq[i])});
      end
      sl_mode = 1;
      flip_k  = 0;
      @(negedge clk);
      ch_mask = 8'b1010_0100;
      scan_en = 1'b1;
      single  = 1'b1;
      channel = 3'd0;
      start   = 1'b1;
      @(posedge clk);
      #1;
      start          = 1'b0;
      dv_seen        = 0;
      busy_fall      = -1;
      drop_at        = -1;
      busy_low_early = 0;
      for (int j = 1; j <= 5 * P + 100 && busy_fall < 0; j++) begin
         @(posedge clk);
         #1;
         if (data_valid) begin
            if (dv_seen < 5) dv_at[dv_seen] = j;
            dv_seen++;
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL scan_extra_valid: got ch=%0d, want no further frame", adc_ch);
            end else begin
               e = exp_q.pop_front();
               if ({data_err, adc_ch, adc_data} !== e) begin
                  n_fail++;
                  $display("FAIL scan_frame%0d: got err=%0b ch=%0d data=%0h, want err=%0b ch=%0d data=%0h",
                           dv_seen, data_err, adc_ch, adc_data, e.err, e.ch, e.data);
               end
            end
         end
         if (dv_seen == 4 && drop_at < 0 && !CS) drop_at = j + 20;
         if (j == drop_at) scan_en = 1'b0;
         if (!busy) begin
            if (dv_seen < 5) busy_low_early++;
            else busy_fall = j;
         end
      end
      n_tests++;
      if (dv_seen != 5 || busy_low_early != 0) begin
         n_fail++;
         $display("FAIL scan_frames: got %0d results, %0d idle cycles, want 5 results, 0 idle",
                  dv_seen, busy_low_early);
      end
      n_tests++;
      if (dv_at[1] - dv_at[0] != P) begin
         n_fail++;
         $display("FAIL scan_period: got %0d cycles, want %0d", dv_at[1] - dv_at[0], P);
      end
      n_tests++;
      if (busy_fall - dv_at[4] != GAP) begin
         n_fail++;
         $display("FAIL scan_stop_busy: got %0d cycles after last result, want %0d",
                  busy_fall - dv_at[4], GAP);
      end
      frames_end = frames;
      repeat (2 * P) @(posedge clk);
      n_tests++;
      if (frames != frames_end || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scan_no_more_frames: got %0d extra frames, %0d pending, want 0 and 0",
                  frames - frames_end, exp_q.size());
         exp_q.delete();
      end
      ch_mask = '0;
   endtask

   task automatic test_start_ignored();
      int   f0, dv_cnt, cs_low, busy_hi;
      exp_t e;
      sl_mode  = 0;
      sl_fixed = DW'(10'h2AA);
      flip_k   = 0;
      exp_q.push_back({1'b0, 3'd1, DW'(10'h2AA)});
      f0 = frames;
      @(negedge clk);
      scan_en = 1'b0;
      single  = 1'b1;
      channel = 3'd1;
      start   = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
      dv_cnt = 0;
      for (int j = 1; j <= TDV + GAP + 10; j++) begin
         @(posedge clk);
         #1;
         if (j == 40) begin
            start   = 1'b1;
            channel = 3'd6;
         end
         if (j == 41) start = 1'b0;
         if (data_valid) begin
            dv_cnt++;
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               n_tests++;
               if ({data_err, adc_ch, adc_data} !== e) begin
                  n_fail++;
                  $display("FAIL busy_start_result: got ch=%0d data=%0h, want ch=%0d data=%0h",
                           adc_ch, adc_data, e.ch, e.data);
               end
            end
         end
      end
      n_tests++;
      if (frames - f0 != 1 || dv_cnt != 1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL busy_start_ignored: got %0d frames %0d results busy=%b, want 1 1 0",
                  frames - f0, dv_cnt, busy);
         exp_q.delete();
      end
      @(negedge clk);
      scan_en = 1'b1;
      ch_mask = '0;
      start   = 1'b1;
      cs_low  = 0;
      busy_hi = 0;
      for (int j = 1; j <= 50; j++) begin
         @(posedge clk);
         #1;
         if (j == 3) start = 1'b0;
         if (!CS) cs_low++;
         if (busy) busy_hi++;
      end
      n_tests++;
      if (cs_low != 0 || busy_hi != 0) begin
         n_fail++;
         $display("FAIL empty_mask: got %0d CS-low and %0d busy cycles, want 0 and 0", cs_low, busy_hi);
      end
      start   = 1'b0;
      scan_en = 1'b0;
   endtask

   task automatic test_reset_midframe();
      int dv_cnt, cs_low;
      sl_mode  = 0;
      sl_fixed = DW'(10'h3FF);
      flip_k   = 0;
      @(negedge clk);
      scan_en = 1'b0;
      single  = 1'b1;
      channel = 3'd3;
      start   = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      // One cycle past SCK rise 9.
      repeat (2 + 17 * CD) @(posedge clk);
      #1;
      n_tests++;
      if ({CS, SCK} !== 2'b01) begin
         n_fail++;
         $display("FAIL midframe_position: got CS=%b SCK=%b, want CS=0 SCK=1", CS, SCK);
      end
      #2;
      rst = 1'b1;
      #1;
      n_tests++;
      if ({CS, SCK, MOSI, busy, data_valid} !== 5'b10000) begin
         n_fail++;
         $display("FAIL async_reset: got CS/SCK/MOSI/busy/dv=%b, want 10000",
                  {CS, SCK, MOSI, busy, data_valid});
      end
      dv_cnt = 0;
      cs_low = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int j = 1; j <= 2 * N * CD + GAP; j++) begin
         @(posedge clk);
         #1;
         if (data_valid) dv_cnt++;
         if (!CS) cs_low++;
      end
      n_tests++;
      if (dv_cnt != 0 || cs_low != 0) begin
         n_fail++;
         $display("FAIL aborted_frame: got %0d results %0d CS-low cycles, want 0 and 0", dv_cnt, cs_low);
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst     = 1'b1;
      start   = 1'b0;
      scan_en = 1'b0;
      single  = 1'b0;
      channel = 3'd0;
      ch_mask = '0;
      test_reset();
      test_single_conv("se_ch2", 1'b1, 3'd2, DW'(10'h150), 0, 1'b0);
      test_single_conv("diff_ch5", 1'b0, 3'd5, DW'(10'h2C3), 0, 1'b0);
      test_scan();
      test_start_ignored();
      test_reset_midframe();
      test_single_conv("after_reset_ch0", 1'b1, 3'd0, DW'(10'h1A5), 0, 1'b0);
`ifdef SPI_ADC_LSBCHK_EN
      test_single_conv("lsbchk_ok", 1'b1, 3'd6, DW'(12'hABC), 0, 1'b0);
      test_single_conv("lsbchk_flip", 1'b1, 3'd6, DW'(12'hABC), 10 + DW, 1'b1);
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
